// File: rtl/chroma_keyer_pkg.sv
// Shared definitions for the chroma keyer: default widths and frame FSM encoding.
package chroma_keyer_pkg;

    localparam int DW_DEFAULT = 12;
    localparam int CW_DEFAULT = 20;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        IN_FRAME = 2'd1,
        EOF      = 2'd2
    } frame_state_t;

endpackage

// File: rtl/chroma_keyer_key_compare.sv
// Two-stage green-dominance compare and background mux.
// Stage 1 registers pixel and widened sums; stage 2 registers decision and output.
module key_compare
    import chroma_keyer_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [DW-1:0] red_i,
    input  logic [DW-1:0] green_i,
    input  logic [DW-1:0] blue_i,
    input  logic          valid_i,
    input  logic          frame_i,
    input  logic [DW-1:0] thr_i,
    input  logic          key_en_i,
    input  logic [DW-1:0] bg_red_i,
    input  logic [DW-1:0] bg_green_i,
    input  logic [DW-1:0] bg_blue_i,
    output logic [DW-1:0] red_o,
    output logic [DW-1:0] green_o,
    output logic [DW-1:0] blue_o,
    output logic          valid_o,
    output logic          mask_o,
    output logic          frame_o
);

    logic [3*DW-1:0] pix_in;
    logic [3*DW-1:0] bg_in;
    logic [3*DW-1:0] pix_s1;
    logic [3*DW-1:0] pix_out;
    logic [DW:0]     rt_q;
    logic [DW:0]     bt_q;
    logic            valid_q;
    logic            frame_q;
    logic            valid2_q;
    logic            mask_q;
    logic            frame2_q;
    logic            key_hit;

    assign pix_in = {blue_i, green_i, red_i};
    assign bg_in  = {bg_blue_i, bg_green_i, bg_red_i};

    // Sums are one bit wider than the components so R+T and B+T never wrap.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rt_q     <= '0;
            bt_q     <= '0;
            valid_q  <= 1'b0;
            frame_q  <= 1'b0;
            valid2_q <= 1'b0;
            mask_q   <= 1'b0;
            frame2_q <= 1'b0;
        end else begin
            rt_q     <= {1'b0, red_i} + {1'b0, thr_i};
            bt_q     <= {1'b0, blue_i} + {1'b0, thr_i};
            valid_q  <= valid_i;
            frame_q  <= frame_i;
            valid2_q <= valid_q;
            frame2_q <= frame_q;
            if (valid_q) begin
                mask_q <= key_hit;
            end
        end
    end

    assign key_hit = key_en_i
                   && ({1'b0, pix_s1[DW +: DW]} > rt_q)
                   && ({1'b0, pix_s1[DW +: DW]} > bt_q);

    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        logic [DW-1:0] pix_q;
        logic [DW-1:0] out_q;

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                pix_q <= '0;
                out_q <= '0;
            end else begin
                pix_q <= pix_in[gi*DW +: DW];
                if (valid_q) begin
                    out_q <= key_hit ? bg_in[gi*DW +: DW] : pix_q;
                end
            end
        end

        assign pix_s1[gi*DW +: DW]  = pix_q;
        assign pix_out[gi*DW +: DW] = out_q;
    end

    assign red_o   = pix_out[0 +: DW];
    assign green_o = pix_out[DW +: DW];
    assign blue_o  = pix_out[2*DW +: DW];
    assign valid_o = valid2_q;
    assign mask_o  = mask_q;
    assign frame_o = frame2_q;

endmodule

// File: rtl/chroma_keyer.sv
// Chroma keyer top: per-frame configuration latch, frame FSM and keyed-pixel
// counter around the key_compare datapath.
module chroma_keyer
    import chroma_keyer_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int CW = CW_DEFAULT
) (
    input  logic          iCLK,
    input  logic          iRST_N,
    input  logic [DW-1:0] iRed,
    input  logic [DW-1:0] iGreen,
    input  logic [DW-1:0] iBlue,
    input  logic          iDataValid,
    input  logic          iFrameValid,
    input  logic          iKeyEnable,
    input  logic [DW-1:0] iThreshold,
    input  logic [DW-1:0] iBgRed,
    input  logic [DW-1:0] iBgGreen,
    input  logic [DW-1:0] iBgBlue,
    output logic [DW-1:0] oRed,
    output logic [DW-1:0] oGreen,
    output logic [DW-1:0] oBlue,
    output logic          oDataValid,
    output logic          oKeyMask,
    output logic [CW-1:0] oKeyCount,
    output logic          oCountValid
);

    frame_state_t  state_q, state_d;
    logic          fv_prev_q;
    logic          sof_pend_q, sof_pend_d;
    logic          act_en_q, act_en_d;
    logic [DW-1:0] act_thr_q, act_thr_d;
    logic [DW-1:0] act_bg_r_q, act_bg_r_d;
    logic [DW-1:0] act_bg_g_q, act_bg_g_d;
    logic [DW-1:0] act_bg_b_q, act_bg_b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] key_count_q, key_count_d;
    logic          count_valid_q, count_valid_d;
    logic          s2_frame;
    logic          s2_frame_prev_q;
    logic          fv_rise;
    logic          s2_fall;

    assign fv_rise = iFrameValid & ~fv_prev_q;
    assign s2_fall = s2_frame_prev_q & ~s2_frame;

    // Stage 1 sees act_thr_d so the first pixel of a frame already uses the
    // threshold captured at its own SOF edge.
    key_compare #(.DW(DW)) u_key_compare (
        .clk_i      (iCLK),
        .rst_n_i    (iRST_N),
        .red_i      (iRed),
        .green_i    (iGreen),
        .blue_i     (iBlue),
        .valid_i    (iDataValid),
        .frame_i    (iFrameValid),
        .thr_i      (act_thr_d),
        .key_en_i   (act_en_q),
        .bg_red_i   (act_bg_r_q),
        .bg_green_i (act_bg_g_q),
        .bg_blue_i  (act_bg_b_q),
        .red_o      (oRed),
        .green_o    (oGreen),
        .blue_o     (oBlue),
        .valid_o    (oDataValid),
        .mask_o     (oKeyMask),
        .frame_o    (s2_frame)
    );

    always_comb begin
        state_d       = state_q;
        sof_pend_d    = sof_pend_q;
        act_en_d      = act_en_q;
        act_thr_d     = act_thr_q;
        act_bg_r_d    = act_bg_r_q;
        act_bg_g_d    = act_bg_g_q;
        act_bg_b_d    = act_bg_b_q;
        cnt_d         = cnt_q;
        key_count_d   = key_count_q;
        count_valid_d = 1'b0;
        case (state_q)
            WAIT_SOF: begin
                if (fv_rise || sof_pend_q) begin
                    act_en_d   = iKeyEnable;
                    act_thr_d  = iThreshold;
                    act_bg_r_d = iBgRed;
                    act_bg_g_d = iBgGreen;
                    act_bg_b_d = iBgBlue;
                    cnt_d      = '0;
                    sof_pend_d = 1'b0;
                    state_d    = IN_FRAME;
                end
            end
            IN_FRAME: begin
                if (oDataValid && oKeyMask && s2_frame && (cnt_q != {CW{1'b1}})) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (s2_fall) begin
                    state_d = EOF;
                end
                if (fv_rise) begin
                    sof_pend_d = 1'b1;
                end
            end
            EOF: begin
                key_count_d   = cnt_q;
                count_valid_d = 1'b1;
                state_d       = WAIT_SOF;
                // A new frame starting right now is picked up from WAIT_SOF next cycle.
                if (fv_rise) begin
                    sof_pend_d = 1'b1;
                end
            end
            default: begin
                state_d = WAIT_SOF;
            end
        endcase
    end

    // fv_prev_q resets high so a frame already running at reset release is
    // not mistaken for a start of frame and is never counted.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q         <= WAIT_SOF;
            fv_prev_q       <= 1'b1;
            sof_pend_q      <= 1'b0;
            act_en_q        <= 1'b0;
            act_thr_q       <= '0;
            act_bg_r_q      <= '0;
            act_bg_g_q      <= '0;
            act_bg_b_q      <= '0;
            cnt_q           <= '0;
            key_count_q     <= '0;
            count_valid_q   <= 1'b0;
            s2_frame_prev_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            fv_prev_q       <= iFrameValid;
            sof_pend_q      <= sof_pend_d;
            act_en_q        <= act_en_d;
            act_thr_q       <= act_thr_d;
            act_bg_r_q      <= act_bg_r_d;
            act_bg_g_q      <= act_bg_g_d;
            act_bg_b_q      <= act_bg_b_d;
            cnt_q           <= cnt_d;
            key_count_q     <= key_count_d;
            count_valid_q   <= count_valid_d;
            s2_frame_prev_q <= s2_frame;
        end
    end

    assign oKeyCount   = key_count_q;
    assign oCountValid = count_valid_q;

endmodule

// File: doc/chroma_keyer.md
CHROMA_KEYER -- requirements
Module: chroma_keyer

Interface
REQ-001 SHALL have parameter DW, default 12, the colour component width, matching the RAW-to-RGB converter output.
REQ-002 SHALL have parameter CW, default 20, the keyed-pixel counter width.
REQ-003 SHALL have port iCLK, input, 1 bit, the pixel clock (CCD_PIXCLK domain); one clock only.
REQ-004 SHALL have port iRST_N, input, 1 bit, the reset; asynchronous, active-low.
REQ-005 SHALL have ports iRed, iGreen and iBlue, each input, DW bits, the converted pixel components.
REQ-006 SHALL have port iDataValid, input, 1 bit, which qualifies iRed, iGreen and iBlue.
REQ-007 SHALL have port iFrameValid, input, 1 bit, the registered camera frame-valid.
REQ-008 SHALL have port iKeyEnable, input, 1 bit; when 1, keying is applied.
REQ-009 SHALL have port iThreshold, input, DW bits, the green dominance margin.
REQ-010 SHALL have ports iBgRed, iBgGreen and iBgBlue, each input, DW bits, the replacement colour.
REQ-011 SHALL have ports oRed, oGreen and oBlue, each output, DW bits, the keyed pixel.
REQ-012 SHALL have port oDataValid, output, 1 bit, which qualifies oRed, oGreen, oBlue and oKeyMask.
REQ-013 SHALL have port oKeyMask, output, 1 bit; it is 1 when the output pixel was replaced.
REQ-014 SHALL have port oKeyCount, output, CW bits, the keyed-pixel total of the last complete frame.
REQ-015 SHALL have port oCountValid, output, 1 bit, a one-cycle pulse when oKeyCount updates.

Function
REQ-016 SHALL have a fixed pixel latency of 2 cycles: a pixel sampled with iDataValid=1 at edge N appears with oDataValid=1 at edge N+2.
REQ-017 SHALL carry no back-pressure: every valid input produces exactly one valid output, with no stalls or drops.
REQ-018 SHALL compute the key condition as (G > R + T) AND (G > B + T), using DW+1-bit sums so the addition cannot wrap.
REQ-019 SHALL treat T = 0 as keying on strict green dominance only.
REQ-020 SHALL keep stage 1 as registered R, G, B, R+T, B+T, valid and a frame flag.
REQ-021 SHALL have stage 2 register the comparison result and the output mux.
REQ-022 SHALL output the active background colour with oKeyMask=1 when the key condition holds and the active enable is 1.
REQ-023 SHALL otherwise pass the input components unchanged with oKeyMask=0.
REQ-024 SHALL hold oRed, oGreen, oBlue and oKeyMask at their last values when oDataValid=0.
REQ-025 SHALL use a frame FSM with states WAIT_SOF, IN_FRAME and EOF.
REQ-026 SHALL, in WAIT_SOF, on a rising edge of iFrameValid (previous sample 0, current 1), capture iKeyEnable, iThreshold and iBg* into active registers, clear the counter, and go to IN_FRAME.
REQ-027 SHALL, in IN_FRAME, count stage-2 pixels that have oDataValid=1 and oKeyMask=1 and a frame flag of 1.
REQ-028 SHALL go from IN_FRAME to EOF when the stage-2 frame flag falls, so that in-flight pixels are counted.
REQ-029 SHALL, in EOF, for one cycle, load oKeyCount, pulse oCountValid, and return to WAIT_SOF.
REQ-030 SHALL, after reset, key the partial frame in progress with the reset-default active values.
REQ-031 SHALL never count or report that partial frame; the first report follows the first full frame.
REQ-032 SHALL use the active registers, which change only at SOF; configuration inputs changing mid-frame SHALL NOT affect the current frame.
REQ-033 SHALL saturate the counter at 2^CW-1, without wrap.
REQ-034 SHALL count a pixel with iDataValid=1 while iFrameValid=0 toward no frame, while still processing it normally.
REQ-035 SHALL handle a rising iFrameValid that coincides with the EOF state by completing EOF first, then detecting the SOF in WAIT_SOF on the next cycle via the stored previous sample.

Reset
REQ-036 SHALL clear all pipeline registers, oRed, oGreen, oBlue, oDataValid, oKeyMask, oKeyCount, oCountValid and the counter to 0 while iRST_N=0.
REQ-037 SHALL set the FSM to WAIT_SOF and the active enable to 0 while iRST_N=0.
REQ-038 SHALL abandon any frame in progress when reset is asserted mid-frame, producing no oCountValid for it.

Structure
REQ-039 SHALL place the FSM state encoding and the default DW/CW constants in the shared project package.
REQ-040 SHALL instantiate one sub-module, key_compare, holding the two-stage compare/mux datapath; the FSM and counter stay in the top.

Verification
REQ-041 SHALL cover: T=16, pixel R=100 G=200 B=50, enable=1 -> 2 cycles later output equals background, oKeyMask=1.
REQ-042 SHALL cover: T=16, pixel R=100 G=116 B=50 -> passed unchanged, oKeyMask=0 (equality boundary).
REQ-043 SHALL cover: R=G=B=4095, T=4095 -> no overflow and no key; G=4095 R=B=0 T=0 -> keyed.
REQ-044 SHALL cover: a full frame of 640x480 valid pixels with 1000 keyed -> oKeyCount=1000 with a single oCountValid pulse, including keyed pixels in the last two cycles before iFrameValid falls.
REQ-045 SHALL cover: iThreshold changed mid-frame -> the remainder of the frame uses the old T, and the next frame uses the new T.
REQ-046 SHALL cover: reset asserted mid-frame, then one full frame -> no pulse for the aborted frame and a correct count for the full frame; CW=4 with 20 keyed pixels -> oKeyCount=15.
